spike_frame_encoder: RTL
========================

# spike_frame_encoder

Input-side encoder for the spiking network. It accepts one frame of N time-to-first-spike values over an AXI-stream `axis_if` slave port and buffers them. It then replays the frame as per-input spike pulses across TS time steps, generating the network `time_step` strobe and a network reset pulse. It drives the synapse `spike` inputs that neurons consume; neurons report first-spike times back out in the same encoding.

## Interface
Parameters:
- `N`, 4 — number of encoded inputs (frame length in beats); N ≥ 1.
- `TSP`, 4 — clocks per time step; TSP ≥ 2.
- `TS` — taken from `snn_pkg` (time steps per frame); not a module parameter.

Ports:
- `clk`  input  1  — single clock; all logic on posedge.
- `reset`  input  1  — synchronous, active-high.
- `axis_in`  axis_if slave  tdata width TW = $clog2(TS+1)  — frame input; `tvalid`/`tdata`/`tlast` in, `tready` out.
- `spike`  output  N  — per-input spike, held for a whole time step.
- `time_step`  output  1  — one-clock strobe on the last clock of each step.
- `net_reset`  output  1  — one-clock pulse clearing downstream neurons before a frame runs.
- `frame_done`  output  1  — one-clock pulse after the final step.
- `busy`  output  1  — high in RUN and DONE.

## Operation
- FSM states: LOAD, START, RUN, DONE. Reset enters LOAD.
- LOAD:
  - `tready` = 1; a beat is accepted when `tvalid & tready`.
  - Beat k writes `mem[k]` (k = 0..N-1, write pointer `wp`).
  - The frame ends on the accepted beat with `tlast` = 1, or on beat N-1, whichever comes first.
  - Early `tlast`: entries wp+1..N-1 are loaded with TS (silent).
  - Beat N-1 without `tlast`: the frame ends anyway and no error is flagged.
  - On frame end → START.
- START: one clock. `net_reset` = 1, `tready` = 0; clear `step_idx` and `div` → RUN.
- RUN:
  - `div` counts 0..TSP-1; `time_step` = (div == TSP-1).
  - `step_idx` increments after each strobe.
  - `spike[j]` = (mem[j] == step_idx), a function of registers only.
  - Values ≥ TS never spike. Value 0 spikes in step 0.
  - On the strobe where step_idx == TS-1 → DONE.
- DONE: one clock. `frame_done` = 1, `spike` = 0 → LOAD with `wp` = 0.
- Outside RUN: `spike` = 0, `time_step` = 0, `tready` = 0 (except in LOAD).
- Width rules:
  - `step_idx` and `mem` entries are TW bits, so TS is representable.
  - `div` is $clog2(TSP) bits.
  - Comparisons are unsigned.

## Timing
- Reset values: `spike` = 0, `time_step` = 0, `net_reset` = 0, `frame_done` = 0, `busy` = 0. `tready` = 1 in the first clock after reset deasserts. `wp` = 0. All `mem` entries = TS.
- Latency, last accepted beat → `net_reset`: 1 clock. `net_reset` → first RUN clock: 1 clock.
- `spike[j]` for step s is valid from the first clock of that step through its strobe, so neurons sample it on `time_step`.
- RUN lasts exactly TS·TSP clocks. Frame period = beats + 2 + TS·TSP clocks.
- `tready` is registered from state. The slave never accepts a beat in START, RUN or DONE. `tvalid` may stay high across frames; the beat is taken on the first LOAD clock.
- Reset mid-frame (any state) returns to LOAD on the next clock: `mem` refilled with TS, outputs at reset values, partially loaded data discarded.

## Structure
- `snn_pkg` holds TS and `typedef enum {LOAD, START, RUN, DONE} enc_state_t`. TW is derived locally from TS.
- `axis_if` is reused unchanged.
- Sub-module `time_step_gen`:
  - Parameter TSP.
  - Inputs: `clk`, `reset`, `run`.
  - Outputs: `time_step`, `last` (div == TSP-1).
  - The encoder owns `step_idx`.
- `mem` is an N-entry register array; no RAM inference.

## Test plan
(N=4, TS=8, TSP=4 unless noted.)
- Full frame 0,3,7,8 with `tlast` on beat 3 → one `net_reset`. spike[0] in step 0 only, spike[1] in step 3, spike[2] in step 7, spike[3] never. 8 `time_step` strobes 4 clocks apart, then `frame_done`.
- Early `tlast` on beat 1 (values 2,5) → spike[0] step 2, spike[1] step 5, spike[2..3] silent; the next frame starts at `wp` = 0.
- 4 beats with `tlast` never asserted → frame ends after beat 3; the 5th beat is held off (`tready` = 0) until DONE → LOAD, then accepted as beat 0 of the next frame.
- `tvalid` held high continuously for 3 frames → frame period exactly 4+2+32 = 38 clocks; no beat lost or duplicated.
- Reset asserted in RUN at step 4 → next clock all outputs 0 and `tready` = 1. A new frame 1,1,1,1 spikes all inputs in step 1 with no residue from the old frame.
- TSP=2, TS=8: value 7 → spike[j] high during clocks 14–15 of RUN, with `time_step` on clock 15.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared constants and types for the spiking-network input side.
// TS is the number of time steps replayed per frame.
package snn_pkg;

    localparam int TS = 8;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } enc_state_t;

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-stream bundle: valid/ready handshake with data and end-of-frame marker.
interface axis_if #(
    parameter int TW = 4
);
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic [TW-1:0] tdata;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/time_step_gen.sv
// Divides the clock into time steps of TSP clocks while run is high.
// time_step strobes on the last clock of each step.
module time_step_gen #(
    parameter int TSP = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic time_step,
    output logic last
);
    localparam int DW = (TSP > 1) ? $clog2(TSP) : 1;

    logic [DW-1:0] div_r;

    assign last      = (div_r == DW'(TSP - 1));
    assign time_step = run & last;

    // Clock-within-step counter, held at zero whenever not running
    always_ff @(posedge clk) begin
        if (reset) begin
            div_r <= '0;
        end else if (!run || last) begin
            div_r <= '0;
        end else begin
            div_r <= div_r + DW'(1);
        end
    end
endmodule

// File: rtl/spike_frame_encoder.sv
// Buffers one frame of time-to-first-spike values from AXI-stream, then replays
// it as per-input spikes over TS time steps with step strobes and a neuron reset.
module spike_frame_encoder
    import snn_pkg::*;
#(
    parameter int N   = 4,
    parameter int TSP = 4
) (
    input  logic         clk,
    input  logic         reset,
    axis_if.slave        axis_in,
    output logic [N-1:0] spike,
    output logic         time_step,
    output logic         net_reset,
    output logic         frame_done,
    output logic         busy
);
    localparam int             TW      = $clog2(TS + 1);
    localparam int             WPW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [TW-1:0]  SILENT  = TW'(TS);
    localparam logic [TW-1:0]  LAST_ST = TW'(TS - 1);
    localparam logic [WPW-1:0] WP_LAST = WPW'(N - 1);

    enc_state_t     state_r, state_s;
    logic [TW-1:0]  mem_r [N];
    logic [WPW-1:0] wp_r;
    logic [TW-1:0]  step_idx_r;
    logic           tready_r, net_reset_r, frame_done_r, busy_r;
    logic           run_s, ts_s, ts_last_s, accept_s, frame_end_s;

    assign run_s       = (state_r == RUN);
    assign accept_s    = (state_r == LOAD) & axis_in.tvalid;
    assign frame_end_s = accept_s & (axis_in.tlast | (wp_r == WP_LAST));

    time_step_gen #(.TSP(TSP)) u_tsg (
        .clk       (clk),
        .reset     (reset),
        .run       (run_s),
        .time_step (ts_s),
        .last      (ts_last_s)
    );

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            LOAD: begin
                if (frame_end_s) state_s = START;
                else             state_s = LOAD;
            end
            START: state_s = RUN;
            RUN: begin
                if (ts_last_s && (step_idx_r == LAST_ST)) state_s = DONE;
                else                                      state_s = RUN;
            end
            DONE:    state_s = LOAD;
            default: state_s = LOAD;
        endcase
    end

    // State register and outputs registered from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= LOAD;
            tready_r     <= 1'b1;
            net_reset_r  <= 1'b0;
            frame_done_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            tready_r     <= (state_s == LOAD);
            net_reset_r  <= (state_s == START);
            frame_done_r <= (state_s == DONE);
            busy_r       <= (state_s == RUN) || (state_s == DONE);
        end
    end

    // Frame buffer, write pointer and step index
    always_ff @(posedge clk) begin
        if (reset) begin
            wp_r       <= '0;
            step_idx_r <= '0;
            for (int j = 0; j < N; j++) mem_r[j] <= SILENT;
        end else begin
            if (accept_s) begin
                // An early tlast leaves the untouched tail silent
                for (int j = 0; j < N; j++) begin
                    if (axis_in.tlast && (WPW'(j) > wp_r)) mem_r[j] <= SILENT;
                end
                mem_r[wp_r] <= axis_in.tdata;
                wp_r        <= frame_end_s ? '0 : wp_r + WPW'(1);
            end
            if (state_r == START) begin
                step_idx_r <= '0;
            end else if (ts_s) begin
                step_idx_r <= step_idx_r + TW'(1);
            end
        end
    end

    // Spikes depend only on registers, so they are stable across a whole step
    always_comb begin
        spike = '0;
        for (int j = 0; j < N; j++) begin
            if (run_s && (mem_r[j] == step_idx_r)) spike[j] = 1'b1;
            else                                   spike[j] = 1'b0;
        end
    end

    assign axis_in.tready = tready_r;
    assign time_step      = ts_s;
    assign net_reset      = net_reset_r;
    assign frame_done     = frame_done_r;
    assign busy           = busy_r;
endmodule
